trees_stream_loader: RTL and testbench

Front-end sequencer for the tree-ensemble classifier. Accepts a 64-bit valid/ready word stream and a command, writes tree node words into the ensemble's per-tree node memories, packs feature words into the feature vector, and pulses the ensemble's start. It then waits for the ensemble's done and returns the prediction on a valid/ready result port.

---
 rtl/trees_stream_loader.sv | 207 ++++++++++++++++++++
 tb/tb_trees_stream_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trees_stream_loader.sv
// Stream front-end for the tree-ensemble classifier: loads node words and features, runs one
// inference and returns its class. Optional watchdog in WAIT: define TREES_LOADER_TIMEOUT_EN.
module trees_stream_loader #(
  parameter int unsigned N_TREES          = 16,
  parameter int unsigned N_NODE_AND_LEAFS = 256,
  parameter int unsigned N_FEATURE        = 32,
  parameter int unsigned TIMEOUT          = 4096
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_op,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [63:0]                         in_data,
  input  logic                                in_last,
  output logic                                load_trees,
  output logic [$clog2(N_NODE_AND_LEAFS)-1:0] n_node,
  output logic [$clog2(N_TREES)-1:0]          n_tree,
  output logic [63:0]                         tree_nodes,
  output logic [N_FEATURE*32-1:0]             features,
  output logic                                start,
  input  logic                                done,
  input  logic [7:0]                          prediction,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [7:0]                          res_class,
  output logic                                res_err,
  output logic                                len_err
);

  localparam int unsigned NW = $clog2(N_NODE_AND_LEAFS);
  localparam int unsigned TW = $clog2(N_TREES);
  localparam int unsigned FW = (N_FEATURE > 2) ? $clog2(N_FEATURE / 2) : 1;
  localparam logic [NW-1:0] NodeLast = NW'(N_NODE_AND_LEAFS - 1);
  localparam logic [TW-1:0] TreeLast = TW'(N_TREES - 1);
  localparam logic [FW-1:0] FeatLast = FW'(N_FEATURE / 2 - 1);

  typedef enum logic [2:0] {StIdle, StLoadT, StLoadF, StStart, StWait, StResult} state_e;

  state_e                   state_q, state_d;
  logic [NW-1:0]            node_cnt_q, node_cnt_d, n_node_q, n_node_d;
  logic [TW-1:0]            tree_cnt_q, tree_cnt_d, n_tree_q, n_tree_d;
  logic [FW-1:0]            feat_cnt_q, feat_cnt_d;
  logic                     load_trees_q, load_trees_d;
  logic [63:0]              tree_nodes_q, tree_nodes_d;
  logic [N_FEATURE*32-1:0]  features_q, features_d;
  logic [7:0]               res_class_q, res_class_d;
  logic                     len_err_q, len_err_d;
  logic                     tree_final, feat_final;

`ifdef TREES_LOADER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] ToLast = CW'(TIMEOUT - 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          res_err_q, res_err_d;
  assign res_err = res_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign res_err = 1'b0;
`endif

  assign tree_final = (tree_cnt_q == TreeLast) && (node_cnt_q == NodeLast);
  assign feat_final = (feat_cnt_q == FeatLast);

  always_comb begin
    state_d      = state_q;
    node_cnt_d   = node_cnt_q;
    tree_cnt_d   = tree_cnt_q;
    feat_cnt_d   = feat_cnt_q;
    load_trees_d = 1'b0;
    n_node_d     = n_node_q;
    n_tree_d     = n_tree_q;
    tree_nodes_d = tree_nodes_q;
    features_d   = features_q;
    res_class_d  = res_class_q;
    len_err_d    = len_err_q;
`ifdef TREES_LOADER_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    res_err_d    = res_err_q;
`endif
    cmd_ready    = 1'b0;
    in_ready     = 1'b0;
    start        = 1'b0;
    res_valid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = ~rst;
        if (cmd_valid) begin
          len_err_d  = 1'b0;
          node_cnt_d = '0;
          tree_cnt_d = '0;
          feat_cnt_d = '0;
          state_d    = cmd_op ? StLoadF : StLoadT;
        end
      end
      StLoadT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_trees_d = 1'b1;
          n_node_d     = node_cnt_q;
          n_tree_d     = tree_cnt_q;
          tree_nodes_d = in_data;
          if (node_cnt_q == NodeLast) begin
            node_cnt_d = '0;
            tree_cnt_d = tree_cnt_q + TW'(1);
          end else begin
            node_cnt_d = node_cnt_q + NW'(1);
          end
          if (in_last || tree_final) begin
            // Flags both an early in_last and a full load that lacked in_last.
            len_err_d = in_last ^ tree_final;
            state_d   = StIdle;
          end
        end
      end
      StLoadF: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Word j carries feature 2j in its low half and 2j+1 in its high half.
          features_d[64*int'(feat_cnt_q) +: 64] = in_data;
          feat_cnt_d = feat_cnt_q + FW'(1);
          if (in_last || feat_final) begin
            len_err_d = in_last ^ feat_final;
            state_d   = StStart;
          end
        end
      end
      StStart: begin
        start   = 1'b1;
        state_d = StWait;
`ifdef TREES_LOADER_TIMEOUT_EN
        to_cnt_d = CW'(1);
`endif
      end
      StWait: begin
        if (done) begin
          res_class_d = prediction;
`ifdef TREES_LOADER_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
          state_d     = StResult;
`ifdef TREES_LOADER_TIMEOUT_EN
        end else if (to_cnt_q == ToLast) begin
          res_class_d = '0;
          res_err_d   = 1'b1;
          state_d     = StResult;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
`endif
        end
      end
      StResult: begin
        res_valid = 1'b1;
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      node_cnt_q   <= '0;
      tree_cnt_q   <= '0;
      feat_cnt_q   <= '0;
      load_trees_q <= 1'b0;
      n_node_q     <= '0;
      n_tree_q     <= '0;
      tree_nodes_q <= '0;
      features_q   <= '0;
      res_class_q  <= '0;
      len_err_q    <= 1'b0;
`ifdef TREES_LOADER_TIMEOUT_EN
      to_cnt_q     <= '0;
      res_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      node_cnt_q   <= node_cnt_d;
      tree_cnt_q   <= tree_cnt_d;
      feat_cnt_q   <= feat_cnt_d;
      load_trees_q <= load_trees_d;
      n_node_q     <= n_node_d;
      n_tree_q     <= n_tree_d;
      tree_nodes_q <= tree_nodes_d;
      features_q   <= features_d;
      res_class_q  <= res_class_d;
      len_err_q    <= len_err_d;
`ifdef TREES_LOADER_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      res_err_q    <= res_err_d;
`endif
    end
  end

  assign load_trees = load_trees_q;
  assign n_node     = n_node_q;
  assign n_tree     = n_tree_q;
  assign tree_nodes = tree_nodes_q;
  assign features   = features_q;
  assign res_class  = res_class_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_trees_stream_loader.sv
// Scoreboard bench for trees_stream_loader: stimulus pushes expected node writes and results,
// a negedge monitor pops and compares them; directed checks cover timing and error flags.
`timescale 1ns/1ps
module tb_trees_stream_loader;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, cmd_op;
  logic          in_valid, in_ready, in_last;
  logic [63:0]   in_data;
  logic          load_trees;
  logic [7:0]    n_node;
  logic [3:0]    n_tree;
  logic [63:0]   tree_nodes;
  logic [1023:0] features;
  logic          start, done, res_valid, res_ready, res_err, len_err;
  logic [7:0]    prediction, res_class;

  int checks = 0;
  int errors = 0;
  logic [75:0] wq[$];
  logic [8:0]  rq[$];

  always #5 clk = ~clk;

  trees_stream_loader #(
    .N_TREES(16), .N_NODE_AND_LEAFS(256), .N_FEATURE(32), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .load_trees(load_trees), .n_node(n_node), .n_tree(n_tree), .tree_nodes(tree_nodes),
    .features(features), .start(start), .done(done), .prediction(prediction),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class), .res_err(res_err),
    .len_err(len_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every node write and every accepted result must match the head of its queue.
  always @(negedge clk) begin
    if (load_trees === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", {n_tree, n_node, tree_nodes}, 128'hdead);
      else chk("node_write", {n_tree, n_node, tree_nodes}, wq.pop_front());
    end
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      if (rq.size() == 0) chk("unexpected_result", {res_class, res_err}, 128'hdead);
      else chk("result", {res_class, res_err}, rq.pop_front());
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic op);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    sync();
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] data, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_accept_timeout", 0, 1);
    sync();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("return_idle", cmd_ready, 1);
    sync();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_load_trees"}, load_trees, 0);
    chk({tag, "_addr"}, {n_tree, n_node}, 0);
    chk({tag, "_tree_nodes"}, tree_nodes, 0);
    chk({tag, "_features_zero"}, (features == '0), 1);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_res"}, {res_valid, res_class, res_err}, 0);
    chk({tag, "_len_err"}, len_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; done = 1'b0; prediction = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cmd_ready_in_reset", cmd_ready, 0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    sync();

    // Full tree load, word k = k.
    do_cmd(1'b0);
    for (int k = 0; k < 4096; k++) begin
      wq.push_back({4'(k / 256), 8'(k % 256), 64'(k)});
      send_word(64'(k), k == 4095);
    end
    @(negedge clk);
    @(negedge clk);
    chk("full_load_len_err", len_err, 0);
    chk("full_load_idle", cmd_ready, 1);
    sync();

    // Short tree load: in_last on word 10.
    do_cmd(1'b0);
    for (int k = 0; k <= 10; k++) begin
      wq.push_back({4'd0, 8'(k), 64'hA000 + 64'(k)});
      send_word(64'hA000 + 64'(k), k == 10);
    end
    @(negedge clk);
    @(negedge clk);
    chk("short_load_len_err", len_err, 1);
    chk("short_load_idle", cmd_ready, 1);
    sync();

    // Full INFER; the accepted command must clear len_err.
    do_cmd(1'b1);
    @(negedge clk);
    chk("cmd_clears_len_err", len_err, 0);
    sync();
    for (int j = 0; j < 16; j++) send_word({32'(2 * j + 1), 32'(2 * j)}, j == 15);
    @(negedge clk);
    chk("start_after_last_feature", start, 1);
    chk("feature31", features[31*32 +: 32], 31);
    chk("feature1", features[1*32 +: 32], 1);
    chk("infer_len_err", len_err, 0);
    @(negedge clk);
    chk("start_one_cycle", start, 0);
    chk("in_ready_wait", in_ready, 0);
    repeat (19) @(posedge clk);
    #1;
    done = 1'b1; prediction = 8'd5;
    rq.push_back({8'd5, 1'b0});
    sync();
    done = 1'b0;
    wait_idle();

    // Early in_last at word 3: remaining features keep their previous values.
    do_cmd(1'b1);
    for (int j = 0; j < 4; j++) send_word({32'(256 + 2 * j + 1), 32'(256 + 2 * j)}, j == 3);
    @(negedge clk);
    chk("start_early_end", start, 1);
    chk("early_len_err", len_err, 1);
    chk("early_feature0", features[0 +: 32], 256);
    chk("early_feature7", features[7*32 +: 32], 263);
    chk("kept_feature8", features[8*32 +: 32], 8);
    chk("kept_feature31", features[31*32 +: 32], 31);
    res_ready = 1'b0;
    sync();
    done = 1'b1; prediction = 8'd9;
    rq.push_back({8'd9, 1'b0});
    sync();
    done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_class", res_class, 9);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    sync();
    res_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a tree load, then a fresh load restarts at address 0.
    do_cmd(1'b0);
    for (int k = 0; k < 100; k++) begin
      wq.push_back({4'd0, 8'(k), 64'hE000 + 64'(k)});
      send_word(64'hE000 + 64'(k), 1'b0);
    end
    rst = 1'b1; in_valid = 1'b1; in_data = 64'hE000 + 64'd100;
    sync();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_load_reset");
    sync();
    do_cmd(1'b0);
    for (int k = 0; k < 3; k++) begin
      wq.push_back({4'd0, 8'(k), 64'hF000 + 64'(k)});
      send_word(64'hF000 + 64'(k), k == 2);
    end
    @(negedge clk);
    @(negedge clk);
    chk("fresh_load_len_err", len_err, 1);
    sync();

`ifdef TREES_LOADER_TIMEOUT_EN
    // Watchdog: no done, result with error 64 cycles after start.
    do_cmd(1'b1);
    for (int j = 0; j < 16; j++) send_word(64'(j), j == 15);
    @(negedge clk);
    chk("to_start", start, 1);
    rq.push_back({8'd0, 1'b1});
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      chk("timeout_res_valid", res_valid, (i == 64) ? 1 : 0);
    end
    sync();
    wait_idle();
`endif

    repeat (3) sync();
    chk("write_queue_drained", wq.size(), 0);
    chk("result_queue_drained", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
